// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder with byte-lane writes and range fault
module dmem_responder #(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // RAM contents are deliberately not reset
    logic [31:0] r_mem [0:DEPTH-1];

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic                  w_take;
    logic                  w_enter_resp;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_commit;
    logic [31:0]           w_rd_word;
    logic                  w_unused;

    assign w_take = (r_state == S_IDLE) && mem_valid;

    // With zero wait cycles the response is formed on the accept edge, so the
    // live request fields are used; otherwise only the latched copy is used.
    assign w_addr  = (r_state == S_IDLE) ? mem_addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? mem_wdata : r_wdata;
    assign w_wstrb = (r_state == S_IDLE) ? mem_wstrb : r_wstrb;

    assign w_enter_resp = (w_take && (WAIT_INIT == 4'd0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd1));

    assign w_idx      = w_addr[DEPTH_LOG2+1:2];
    assign w_in_range = (w_addr >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign w_commit   = rst && w_enter_resp && w_in_range && (w_wstrb != 4'd0);
    assign w_rd_word  = r_mem[w_idx];

    // Instruction flag and byte offset carry no meaning for this memory
    assign w_unused = &{1'b0, mem_instr, w_addr[1:0]};

    // Byte-lane RAM write, committed once on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
            if (w_enter_resp) begin
                mem_ready <= 1'b1;
                mem_error <= !w_in_range;
                mem_rdata <= (w_in_range && (w_wstrb == 4'd0)) ? w_rd_word : 32'd0;
            end
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                        r_cnt   <= WAIT_INIT;
                        r_state <= (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_instr, a_ready, a_error;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic        b_valid, b_instr, b_ready, b_error;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wstrb;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(2)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (a_valid),
        .mem_instr (a_instr),
        .mem_addr  (a_addr),
        .mem_wdata (a_wdata),
        .mem_wstrb (a_wstrb),
        .mem_ready (a_ready),
        .mem_rdata (a_rdata),
        .mem_error (a_error)
    );

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (b_valid),
        .mem_instr (b_instr),
        .mem_addr  (b_addr),
        .mem_wdata (b_wdata),
        .mem_wstrb (b_wstrb),
        .mem_ready (b_ready),
        .mem_rdata (b_rdata),
        .mem_error (b_error)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] ref_a [0:4095];
    logic [31:0] ref_b [0:4095];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        return (addr / 32'h4000) == 32'd0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (st[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    // Reference behaviour of one access: returns expected rdata/error, updates model
    task automatic model_a(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                           output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx     = int'((addr % 32'h4000) / 4);
        exp_err = !in_range(addr);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (st == 4'd0) exp_rd = ref_a[idx];
            else ref_a[idx] = merge(ref_a[idx], wd, st);
        end
    endtask

    // One request on the WAIT_CYCLES=2 instance; optionally scramble inputs during WAIT
    task automatic access_a(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                            input bit disturb, output logic [31:0] got_rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        bit          seen;
        model_a(addr, wd, st, exp_rd, exp_err);
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = addr;
        a_wdata = wd;
        a_wstrb = st;
        a_instr = 1'($urandom);
        seen    = 1'b0;
        lat     = 0;
        got_rd  = 32'd0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (disturb && n == 1) begin
                a_addr  = $urandom;
                a_wdata = $urandom;
                a_wstrb = 4'($urandom);
            end
            if (a_ready) begin
                seen   = 1'b1;
                lat    = n;
                got_rd = a_rdata;
                chk("resp_rdata", a_rdata, exp_rd);
                chk("resp_error", 32'(a_error), 32'(exp_err));
            end else begin
                chk("wait_rdata_zero", a_rdata, 32'd0);
                chk("wait_error_zero", 32'(a_error), 32'd0);
            end
        end
        chk("latency", lat, 32'd3);
        a_valid = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", 32'(a_ready), 32'd0);
    endtask

    logic [31:0] rd;
    logic [31:0] op_addr [0:7];
    logic [31:0] op_wd   [0:7];
    logic [3:0]  op_st   [0:7];
    logic [31:0] op_exp  [0:7];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ref_a[i] = 32'd0;
            ref_b[i] = 32'd0;
        end
        rst = 1'b0;
        a_valid = 1'b0; a_instr = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_wstrb = 4'd0;
        b_valid = 1'b0; b_instr = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_wstrb = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_error", 32'(a_error), 32'd0);
        chk("rst_ready_b", 32'(b_ready), 32'd0);
        rst = 1'b1;

        // Known-zero starting contents for the word pool used below
        for (int w = 0; w < 16; w++) access_a(32'(w * 4), 32'd0, 4'hF, 1'b0, rd);

        // Full-word write then read back
        access_a(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        access_a(32'h10, 32'd0, 4'h0, 1'b0, rd);
        chk("deadbeef", rd, 32'hDEADBEEF);

        // Single-lane write merges into existing word
        access_a(32'h20, 32'h11223344, 4'hF, 1'b0, rd);
        access_a(32'h20, 32'h00AA0000, 4'b0100, 1'b0, rd);
        access_a(32'h20, 32'd0, 4'h0, 1'b0, rd);
        chk("lane_merge", rd, 32'h11AA3344);

        // Out-of-range read and write fault without touching the aliased word
        access_a(32'h0000_4000, 32'd0, 4'h0, 1'b0, rd);
        access_a(32'h0000_4010, 32'h12345678, 4'hF, 1'b0, rd);
        access_a(32'h10, 32'd0, 4'h0, 1'b0, rd);
        chk("oor_no_write", rd, 32'hDEADBEEF);

        // Misaligned address reads the containing word
        access_a(32'h13, 32'd0, 4'h0, 1'b0, rd);
        chk("misaligned", rd, 32'hDEADBEEF);

        // Inputs scrambled during WAIT must not affect the latched write
        access_a(32'h24, 32'hCAFEF00D, 4'hF, 1'b1, rd);
        access_a(32'h24, 32'd0, 4'h0, 1'b0, rd);
        chk("latched_write", rd, 32'hCAFEF00D);

        // Reset during WAIT drops the pending write and any response
        @(negedge clk);
        a_valid = 1'b1; a_addr = 32'h10; a_wdata = 32'h0BADF00D; a_wstrb = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_wait_ready", 32'(a_ready), 32'd0);
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(a_ready), 32'd0);
        end
        access_a(32'h10, 32'd0, 4'h0, 1'b0, rd);
        chk("rst_no_write", rd, 32'hDEADBEEF);

        // Randomized mixed traffic over the word pool with occasional faults
        for (int k = 0; k < 40; k++) begin
            logic [31:0] addr;
            logic [3:0]  st;
            addr = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'h4000 << $urandom_range(0, 17));
            st = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            access_a(addr, $urandom, st, 1'($urandom), rd);
        end

        // Zero-wait instance: eight requests with valid held high, ready every 2 cycles
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = (i % 4) * 3 + 1;
            op_addr[i] = 32'(idx * 4);
            op_wd[i]   = $urandom;
            op_st[i]   = (i < 4) ? 4'hF : 4'h0;
            if (i < 4) begin
                ref_b[idx] = op_wd[i];
                op_exp[i]  = 32'd0;
            end else begin
                op_exp[i]  = ref_b[idx];
            end
        end
        @(negedge clk);
        b_valid = 1'b1; b_addr = op_addr[0]; b_wdata = op_wd[0]; b_wstrb = op_st[0];
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                chk("b2b_ready", 32'(b_ready), 32'd1);
                chk("b2b_rdata", b_rdata, op_exp[(k - 1) / 2]);
                chk("b2b_error", 32'(b_error), 32'd0);
                if (k < 15) begin
                    b_addr  = op_addr[(k + 1) / 2];
                    b_wdata = op_wd[(k + 1) / 2];
                    b_wstrb = op_st[(k + 1) / 2];
                end else begin
                    b_valid = 1'b0;
                end
            end else begin
                chk("b2b_gap", 32'(b_ready), 32'd0);
                chk("b2b_gap_rdata", b_rdata, 32'd0);
            end
        end
        @(negedge clk);
        chk("b_idle", 32'(b_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, gives the word-address width of the internal RAM (2**DEPTH_LOG2 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, gives the number of wait cycles inserted before each response (legal range 0-15).
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 mem_valid  input  1  request present; held high with stable fields until mem_ready.
REQ-006 mem_instr  input  1  instruction-fetch flag; SHALL be accepted and otherwise ignored.
REQ-007 mem_addr  input  32  byte address; word index = mem_addr[DEPTH_LOG2+1:2], bits [1:0] ignored.
REQ-008 mem_wdata  input  32  write data, lane-aligned.
REQ-009 mem_wstrb  input  4  byte write strobes; 0000 = read.
REQ-010 mem_ready  output  1  one-cycle response pulse.
REQ-011 mem_rdata  output  32  read data, valid only while mem_ready=1.
REQ-012 mem_error  output  1  access fault, valid only while mem_ready=1.

Function
REQ-013 The block SHALL implement the FSM states IDLE, WAIT, and RESP.
REQ-014 In IDLE with mem_valid=1, the block SHALL latch addr, wdata, and wstrb, load the wait counter with WAIT_CYCLES, and go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-015 In WAIT, the block SHALL decrement the counter each cycle and go to RESP on the cycle it reads 1.
REQ-016 In RESP, the block SHALL drive mem_ready=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-017 Latency: a request first sampled in IDLE at cycle T SHALL get mem_ready=1 in cycle T+1+WAIT_CYCLES.
REQ-018 All outputs SHALL be registered, and mem_ready, mem_rdata, and mem_error SHALL all be 0 in every non-RESP cycle.
REQ-019 Request fields SHALL be taken only from the latched copy; input changes during WAIT or RESP SHALL have no effect.
REQ-020 Out of range (mem_addr[31:DEPTH_LOG2+2] != 0): mem_error=1, mem_rdata=0, and no RAM write.
REQ-021 In-range read (wstrb=0000): mem_rdata = the full addressed word, mem_error=0.
REQ-022 In-range write: for each i with wstrb[i]=1, RAM byte lane i = wdata[8i+7:8i]; other lanes unchanged; mem_rdata=0.
REQ-023 The RAM write SHALL commit exactly once, on the clock edge that enters RESP.
REQ-024 A read in the request following a write to the same word SHALL return the written data.
REQ-025 mem_valid=1 in the IDLE cycle after RESP SHALL be treated as a new request (back-to-back pipelining allowed).
REQ-026 mem_valid=0 in IDLE SHALL keep the block in IDLE with no RAM access.
REQ-027 Misaligned mem_addr[1:0] SHALL NOT fault; alignment is the requester's byte-enable responsibility.

Reset
REQ-028 With rst=0 at a clock edge, the block SHALL go to IDLE, clear the counter, clear the latched request, and set mem_ready=0, mem_rdata=0, and mem_error=0.
REQ-029 Reset during WAIT SHALL discard the pending request, with no RAM write and no mem_ready pulse afterwards.
REQ-030 RAM contents SHALL NOT be reset; simulation SHALL initialise the RAM to all zeros.
REQ-031 The first request SHALL be accepted at the first edge with rst=1 and mem_valid=1.

Verification
REQ-032 Write 0xDEADBEEF to addr 0x10 with wstrb=1111, then read 0x10 -> rdata=0xDEADBEEF, error=0, ready at T+3 for each access (WAIT_CYCLES=2).
REQ-033 Preload 0x11223344 at addr 0x20, write wstrb=0100 with wdata=0x00AA0000, then read -> 0x11AA3344.
REQ-034 Read addr 0x0000_4000 with DEPTH_LOG2=12 -> ready=1, error=1, rdata=0, and RAM unchanged.
REQ-035 WAIT_CYCLES=0, four back-to-back reads with mem_valid held high -> ready pulses every 2 cycles, each with correct data.
REQ-036 Issue a write, assert rst=0 during WAIT, then release and read the same address -> old value returned, and no ready pulse during or after reset.
REQ-037 Change mem_addr and mem_wdata during WAIT -> the response and write use the originally latched values.
